// File: rtl/iram_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iram_isa_pkg
// Brief   : Opcode constants and classification helpers for the instruction RAM ISA.
// Revision: 1.0 - initial release
// ============================================================================
package iram_isa_pkg;

    localparam int unsigned OPC_W = 16;

    localparam logic [OPC_W-1:0] OP_LDAC  = 16'd5;
    localparam logic [OPC_W-1:0] OP_STAC  = 16'd7;
    localparam logic [OPC_W-1:0] OP_LDA   = 16'd9;
    localparam logic [OPC_W-1:0] OP_LDB   = 16'd14;
    localparam logic [OPC_W-1:0] OP_LDC   = 16'd19;
    localparam logic [OPC_W-1:0] OP_STC   = 16'd24;
    localparam logic [OPC_W-1:0] OP_MVACR = 16'd29;
    localparam logic [OPC_W-1:0] OP_MVACC = 16'd30;
    localparam logic [OPC_W-1:0] OP_MVA   = 16'd31;
    localparam logic [OPC_W-1:0] OP_MVB   = 16'd32;
    localparam logic [OPC_W-1:0] OP_MVC   = 16'd33;
    localparam logic [OPC_W-1:0] OP_INAC  = 16'd34;
    localparam logic [OPC_W-1:0] OP_CLAC  = 16'd35;
    localparam logic [OPC_W-1:0] OP_ADD   = 16'd36;
    localparam logic [OPC_W-1:0] OP_SUB   = 16'd38;
    localparam logic [OPC_W-1:0] OP_MUL   = 16'd40;
    localparam logic [OPC_W-1:0] OP_DIV   = 16'd42;
    localparam logic [OPC_W-1:0] OP_MOD   = 16'd44;
    localparam logic [OPC_W-1:0] OP_JUMP  = 16'd46;
    localparam logic [OPC_W-1:0] OP_JPNZ  = 16'd48;
    localparam logic [OPC_W-1:0] OP_NOP   = 16'd50;
    localparam logic [OPC_W-1:0] OP_ENDOP = 16'd51;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_OP_ADDR  = 3'd1,
        S_OP_DATA  = 3'd2,
        S_ARG_ADDR = 3'd3,
        S_ARG_DATA = 3'd4,
        S_ISSUE    = 3'd5,
        S_BR_WAIT  = 3'd6,
        S_HALT     = 3'd7
    } fetch_state_e;

    function automatic logic has_operand(input logic [OPC_W-1:0] op);
        return op inside {OP_LDAC, OP_STAC, OP_LDA, OP_LDB, OP_LDC, OP_STC,
                          OP_JUMP, OP_JPNZ};
    endfunction

    function automatic logic is_legal(input logic [OPC_W-1:0] op);
        return has_operand(op) ||
               (op inside {OP_MVACR, OP_MVACC, OP_MVA, OP_MVB, OP_MVC, OP_INAC,
                           OP_CLAC, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
                           OP_NOP, OP_ENDOP});
    endfunction

endpackage
`default_nettype wire

// File: rtl/isa_decode.sv
`default_nettype none
// ============================================================================
// Module  : isa_decode
// Brief   : Combinational opcode classification used by the fetch FSM.
// Revision: 1.0 - initial release
// ============================================================================
module isa_decode
    import iram_isa_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic             has_operand_o,
    output logic             is_legal_o,
    output logic             is_jump_o,
    output logic             is_jpnz_o,
    output logic             is_end_o
);

    always_comb begin
        has_operand_o = has_operand(opcode_i);
        is_legal_o    = is_legal(opcode_i);
        is_jump_o     = (opcode_i == OP_JUMP);
        is_jpnz_o     = (opcode_i == OP_JPNZ);
        is_end_o      = (opcode_i == OP_ENDOP);
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_unit
// Brief   : Instruction fetch stage: drives IRAM, assembles opcode/operand,
//           issues over valid/ready, redirects on JUMP/JPNZ, stops on ENDOP.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_unit
    import iram_isa_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] iram_addr,
    input  logic [15:0] iram_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_opcode,
    output logic [15:0] instr_operand,
    output logic [15:0] instr_pc,
    input  logic        branch_valid,
    input  logic        branch_taken,
    output logic        halted,
    output logic        illegal
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  opcode_q, opcode_d;
    logic [15:0]  operand_q, operand_d;
    logic [15:0]  ipc_q, ipc_d;
    logic         halted_q, halted_d;
    logic         illegal_q, illegal_d;

    logic [15:0]  dec_opcode;
    logic         dec_has_operand;
    logic         dec_is_legal;
    logic         dec_is_jump;
    logic         dec_is_jpnz;
    logic         dec_is_end;

    // Freshly read RAM word is classified in OP_DATA; the held opcode otherwise.
    assign dec_opcode = (state_q == S_OP_DATA) ? iram_data : opcode_q;

    isa_decode u_isa_decode (
        .opcode_i      (dec_opcode),
        .has_operand_o (dec_has_operand),
        .is_legal_o    (dec_is_legal),
        .is_jump_o     (dec_is_jump),
        .is_jpnz_o     (dec_is_jpnz),
        .is_end_o      (dec_is_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            opcode_q  <= 16'd0;
            operand_q <= 16'd0;
            ipc_q     <= 16'd0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            ipc_q     <= ipc_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        ipc_d     = ipc_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d      = RESET_PC;
                    halted_d  = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = S_OP_ADDR;
                end
            end
            S_OP_ADDR: begin
                state_d = S_OP_DATA;
            end
            S_OP_DATA: begin
                opcode_d = iram_data;
                ipc_d    = pc_q;
                pc_d     = pc_q + 16'd1;
                if (!dec_is_legal) begin
                    illegal_d = 1'b1;
                    halted_d  = 1'b1;
                    state_d   = S_HALT;
                end else if (dec_has_operand) begin
                    state_d = S_ARG_ADDR;
                end else begin
                    operand_d = 16'd0;
                    state_d   = S_ISSUE;
                end
            end
            S_ARG_ADDR: begin
                state_d = S_ARG_DATA;
            end
            S_ARG_DATA: begin
                operand_d = iram_data;
                pc_d      = pc_q + 16'd1;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    if (dec_is_end) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (dec_is_jump) begin
                        pc_d    = operand_q;
                        state_d = S_OP_ADDR;
                    end else if (dec_is_jpnz) begin
                        state_d = S_BR_WAIT;
                    end else begin
                        state_d = S_OP_ADDR;
                    end
                end
            end
            S_BR_WAIT: begin
                // Not-taken falls through: pc already points past the operand.
                if (branch_valid) begin
                    if (branch_taken) begin
                        pc_d = operand_q;
                    end
                    state_d = S_OP_ADDR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign iram_addr     = pc_q;
    assign instr_valid   = (state_q == S_ISSUE);
    assign instr_opcode  = opcode_q;
    assign instr_operand = operand_q;
    assign instr_pc      = ipc_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifetch_unit
// Brief   : Directed bench for ifetch_unit with IRAM model and issue scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] iram_addr;
    logic [15:0] iram_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_opcode;
    logic [15:0] instr_operand;
    logic [15:0] instr_pc;
    logic        branch_valid;
    logic        branch_taken;
    logic        halted;
    logic        illegal;

    typedef struct packed {
        logic [15:0] op;
        logic [15:0] arg;
        logic [15:0] pc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ram [0:65535];
    int          n_tests = 0;
    int          n_fail  = 0;

    ifetch_unit #(.RESET_PC(16'd0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .iram_addr     (iram_addr),
        .iram_data     (iram_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_pc      (instr_pc),
        .branch_valid  (branch_valid),
        .branch_taken  (branch_taken),
        .halted        (halted),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) iram_data <= ram[iram_addr];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_issue"}, {15'd0, instr_valid}, 16'd1);
    endtask

    // Scoreboard: every accepted instruction must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_issue_op", instr_opcode, 16'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_opcode",  instr_opcode,  e.op);
                chk("sb_operand", instr_operand, e.arg);
                chk("sb_pc",      instr_pc,      e.pc);
            end
        end
    end

    initial begin
        int nvalid;
        for (int i = 0; i < 65536; i++) ram[i] = 16'd0;
        ram[0]  = 16'd35;  ram[1]  = 16'd7;   ram[2]  = 16'd6;
        ram[3]  = 16'd46;  ram[4]  = 16'd10;
        ram[10] = 16'd46;  ram[11] = 16'd20;
        ram[20] = 16'd50;  ram[21] = 16'd46;  ram[22] = 16'd67;
        ram[67] = 16'd48;  ram[68] = 16'd14;
        ram[14] = 16'd46;  ram[15] = 16'd67;
        ram[69] = 16'd46;  ram[70] = 16'd98;
        ram[98] = 16'd51;

        rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
        branch_valid = 1'b0; branch_taken = 1'b0;
        tick(); tick();
        chk("rst_iram_addr", iram_addr, 16'd0);
        chk("rst_valid", {15'd0, instr_valid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_illegal", {15'd0, illegal}, 16'd0);
        rst_n = 1'b1;
        tick();

        // First fetch: CLAC at cycle 3, then STAC 6 stalled for 4 cycles.
        instr_ready = 1'b1;
        sb.push_back('{16'd35, 16'd0, 16'd0});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        chk("c2_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        chk("c3_valid", {15'd0, instr_valid}, 16'd1);
        chk("c3_opcode", instr_opcode, 16'd35);
        chk("c3_operand", instr_operand, 16'd0);
        chk("c3_pc", instr_pc, 16'd0);
        sb.push_back('{16'd7, 16'd6, 16'd1});
        tick();
        instr_ready = 1'b0;
        chk("c4_iram_addr", iram_addr, 16'd1);
        repeat (4) tick();
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", {15'd0, instr_valid}, 16'd1);
            chk("stall_opcode", instr_opcode, 16'd7);
            chk("stall_operand", instr_operand, 16'd6);
            chk("stall_pc", instr_pc, 16'd1);
            chk("stall_iram_addr", iram_addr, 16'd3);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        chk("post_accept_valid", {15'd0, instr_valid}, 16'd0);
        chk("post_accept_addr", iram_addr, 16'd3);

        // JUMP chain 3 -> 10 -> 20.
        sb.push_back('{16'd46, 16'd10, 16'd3});
        sb.push_back('{16'd46, 16'd20, 16'd10});
        wait_issue("jump3");
        tick();
        wait_issue("jump10");
        tick();
        chk("jump_target_addr", iram_addr, 16'd20);
        sb.push_back('{16'd50, 16'd0, 16'd20});
        wait_issue("nop20");
        chk("nop_pc", instr_pc, 16'd20);
        tick();
        sb.push_back('{16'd46, 16'd67, 16'd21});
        wait_issue("jump21");
        tick();

        // JPNZ taken; branch_valid during ISSUE must be ignored.
        sb.push_back('{16'd48, 16'd14, 16'd67});
        wait_issue("jpnz_t");
        instr_ready = 1'b0; branch_valid = 1'b1; branch_taken = 1'b1;
        tick();
        chk("bv_in_issue_valid", {15'd0, instr_valid}, 16'd1);
        chk("bv_in_issue_addr", iram_addr, 16'd69);
        branch_valid = 1'b0; instr_ready = 1'b1;
        tick();
        chk("brwait_valid", {15'd0, instr_valid}, 16'd0);
        tick();
        chk("brwait_hold_addr", iram_addr, 16'd69);
        branch_valid = 1'b1; branch_taken = 1'b1;
        tick();
        branch_valid = 1'b0;
        chk("jpnz_taken_addr", iram_addr, 16'd14);
        sb.push_back('{16'd46, 16'd67, 16'd14});
        wait_issue("jump14");
        tick();

        // JPNZ not taken.
        sb.push_back('{16'd48, 16'd14, 16'd67});
        wait_issue("jpnz_nt");
        tick();
        branch_valid = 1'b1; branch_taken = 1'b0;
        tick();
        branch_valid = 1'b0;
        chk("jpnz_nt_addr", iram_addr, 16'd69);
        sb.push_back('{16'd46, 16'd98, 16'd69});
        wait_issue("jump69");
        tick();

        // ENDOP halts; start restarts from RESET_PC.
        sb.push_back('{16'd51, 16'd0, 16'd98});
        wait_issue("endop");
        chk("endop_halted_pre", {15'd0, halted}, 16'd0);
        tick();
        chk("endop_halted", {15'd0, halted}, 16'd1);
        nvalid = 0;
        for (int k = 0; k < 8; k++) begin
            if (instr_valid === 1'b1) nvalid++;
            tick();
        end
        chk("halt_no_valid", nvalid[15:0], 16'd0);
        chk("halt_addr_frozen", iram_addr, 16'd99);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_halted", {15'd0, halted}, 16'd0);
        chk("restart_addr", iram_addr, 16'd0);
        sb.push_back('{16'd35, 16'd0, 16'd0});
        wait_issue("restart_clac");

        // Asynchronous reset while in ARG_DATA of STAC.
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_addr", iram_addr, 16'd0);
        chk("areset_valid", {15'd0, instr_valid}, 16'd0);
        chk("areset_opcode", instr_opcode, 16'd0);
        chk("areset_operand", instr_operand, 16'd0);
        chk("areset_pc", instr_pc, 16'd0);
        chk("areset_halted", {15'd0, halted}, 16'd0);
        chk("areset_illegal", {15'd0, illegal}, 16'd0);
        tick();
        ram[0] = 16'd99;
        rst_n = 1'b1;
        tick();

        // Illegal opcode at RESET_PC.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ill_c2_illegal", {15'd0, illegal}, 16'd0);
        tick();
        chk("ill_illegal", {15'd0, illegal}, 16'd1);
        chk("ill_halted", {15'd0, halted}, 16'd1);
        nvalid = 0;
        for (int k = 0; k < 6; k++) begin
            if (instr_valid === 1'b1) nvalid++;
            tick();
        end
        chk("ill_no_valid", nvalid[15:0], 16'd0);
        chk("sb_drained", sb.size() > 0 ? 16'd1 : 16'd0, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
